mem_access: RTL and testbench

Memory-access stage of the multi-cycle core, between execute and write-back. On entry to stage 4 it decodes load/store instructions, runs one word-aligned transaction on the data bus, and handles byte/halfword lane steering, sign/zero extension, alignment checks and bus timeout. It delivers the extended load value and a one-cycle capture strobe to the write-back stage.

---
 rtl/mem_access.sv | 176 +++++++++++++++++
 tb/tb_mem_access.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: one word-aligned data-bus transaction per entry
// into stage 4, with lane steering, load extension and a bus timeout.
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  stage_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] rs2_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic [31:0] mem_o,
    output logic        wd_q_readin_o,
    output logic        done_o,
    output logic [1:0]  err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [2:0]  stage_q;
    logic        start;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [1:0]  a;
    logic        is_ld, is_st, is_mem;
    logic        legal, mis, go;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  f3_q;
    logic [1:0]  a_q;
    logic        ld_q;
    logic [31:0] cnt, cnt_inc;
    logic        tmo;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val;
    logic        unused_ok;

    assign unused_ok = ^{ir_i[31:15], ir_i[11:7]};

    assign start = (stage_i == 3'd4) && (stage_q != 3'd4)
                && (state == S_IDLE);

    always_comb begin
        opc    = ir_i[6:0];
        f3     = ir_i[14:12];
        a      = addr_i[1:0];
        is_ld  = (opc == 7'b0000011);
        is_st  = (opc == 7'b0100011);
        is_mem = is_ld || is_st;
        legal  = (is_ld && (f3 inside {3'b000, 3'b001, 3'b010,
                                       3'b100, 3'b101}))
              || (is_st && (f3 inside {3'b000, 3'b001, 3'b010}));
        mis    = ((f3[1:0] == 2'b01) && a[0])
              || ((f3[1:0] == 2'b10) && (a != 2'b00));
        go     = is_mem && legal && !mis;
        wdata  = rs2_i;
        be     = 4'b1111;
        unique case (1'b1)
            (f3[1:0] == 2'b00): begin
                wdata = {4{rs2_i[7:0]}};
                be    = 4'b0001 << a;
            end
            (f3[1:0] == 2'b01): begin
                wdata = {2{rs2_i[15:0]}};
                be    = 4'b0011 << {a[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_b   = bus_rdata_i[{a_q, 3'b000} +: 8];
        ld_h   = bus_rdata_i[{a_q[1], 4'b0000} +: 16];
        ld_val = bus_rdata_i;
        unique case (1'b1)
            (f3_q == 3'b000): ld_val = {{24{ld_b[7]}}, ld_b};
            (f3_q == 3'b001): ld_val = {{16{ld_h[15]}}, ld_h};
            (f3_q == 3'b100): ld_val = {24'h0, ld_b};
            (f3_q == 3'b101): ld_val = {16'h0, ld_h};
            default: ;
        endcase
    end

    assign cnt_inc = cnt + 32'd1;
    assign tmo     = (TIMEOUT != 0) && (cnt_inc == 32'(TIMEOUT));

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (start) state_nx = go ? S_BUS : S_DONE;
            S_BUS:  if (bus_ack_i || tmo) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // stage_q resets to 4 so a stage counter parked at 4 needs a fresh entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            stage_q       <= 3'd4;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= 32'h0;
            bus_wdata_o   <= 32'h0;
            bus_be_o      <= 4'h0;
            mem_o         <= 32'h0;
            wd_q_readin_o <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 2'b00;
            f3_q          <= 3'b000;
            a_q           <= 2'b00;
            ld_q          <= 1'b0;
            cnt           <= 32'h0;
        end else begin
            state         <= state_nx;
            stage_q       <= stage_i;
            done_o        <= 1'b0;
            wd_q_readin_o <= 1'b0;
            unique case (state)
                S_IDLE: if (start) begin
                    err_o <= 2'b00;
                    cnt   <= 32'h0;
                    f3_q  <= f3;
                    a_q   <= a;
                    ld_q  <= is_ld;
                    if (go) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= is_st;
                        bus_addr_o  <= {addr_i[31:2], 2'b00};
                        bus_wdata_o <= is_st ? wdata : 32'h0;
                        bus_be_o    <= is_st ? be : 4'h0;
                    end else begin
                        done_o <= 1'b1;
                        if (is_mem && !legal)
                            err_o <= 2'b10;
                        else if (is_mem && mis)
                            err_o <= 2'b01;
                    end
                end
                S_BUS: begin
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        done_o    <= 1'b1;
                        if (ld_q) begin
                            mem_o         <= ld_val;
                            wd_q_readin_o <= 1'b1;
                        end
                    end else if (tmo) begin
                        bus_req_o <= 1'b0;
                        done_o    <= 1'b1;
                        err_o     <= 2'b11;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus queues expected bus and
// completion records, negedge monitors pop and compare.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  stage_i;
    logic [31:0] ir_i, addr_i, rs2_i, bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o, mem_o;
    logic [3:0]  bus_be_o;
    logic        wd_q_readin_o, done_o;
    logic [1:0]  err_o;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(3)) dut (
        .clk(clk), .reset(reset), .stage_i(stage_i), .ir_i(ir_i),
        .addr_i(addr_i), .rs2_i(rs2_i), .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .mem_o(mem_o), .wd_q_readin_o(wd_q_readin_o),
        .done_o(done_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [31:0] mem;
        logic        wd;
        logic [1:0]  err;
        logic [7:0]  reqs;
    } done_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    done_t done_q[$];
    bus_t  bus_q[$];
    int    compared = 0;
    int    mismatched = 0;
    int    dones = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic done_t mk_done(input logic [31:0] m, input logic w,
                                      input logic [1:0] e, input int r);
        done_t d;
        d.mem = m; d.wd = w; d.err = e; d.reqs = 8'(r);
        return d;
    endfunction

    function automatic bus_t mk_bus(input logic we, input logic [31:0] ad,
                                    input logic [31:0] wd, input logic [3:0] b);
        bus_t t;
        t.we = we; t.addr = ad; t.wdata = wd; t.be = b;
        return t;
    endfunction

    // Monitors
    bus_t  cur;
    done_t ed;
    logic  prev_req = 1'b0;
    logic  prev_done = 1'b0;
    int    req_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            req_cnt   = 0;
            prev_req  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("done_width", 32'(done_o), 32'd0);
            if (bus_req_o) begin
                if (!prev_req) begin
                    if (bus_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
                    else cur = bus_q.pop_front();
                end
                req_cnt++;
                chk("bus_we", 32'(bus_we_o), 32'(cur.we));
                chk("bus_addr", bus_addr_o, cur.addr);
                chk("bus_wdata", bus_wdata_o, cur.wdata);
                chk("bus_be", 32'(bus_be_o), 32'(cur.be));
            end
            if (done_o) begin
                dones++;
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    ed = done_q.pop_front();
                    chk("mem_o", mem_o, ed.mem);
                    chk("wd_q_readin", 32'(wd_q_readin_o), 32'(ed.wd));
                    chk("err_o", 32'(err_o), 32'(ed.err));
                    chk("req_cycles", 32'(req_cnt), 32'(ed.reqs));
                end
                req_cnt = 0;
            end else begin
                chk("wd_without_done", 32'(wd_q_readin_o), 32'd0);
            end
            prev_req  = bus_req_o;
            prev_done = done_o;
        end
    end

    task automatic op(input logic [31:0] ir, input logic [31:0] addr,
                      input logic [31:0] rs2, input logic [31:0] rdata,
                      input int ack_dly, input logic has_bus,
                      input bus_t eb, input done_t d);
        int d0;
        @(negedge clk);
        stage_i = 3'd4; ir_i = ir; addr_i = addr; rs2_i = rs2;
        if (has_bus) bus_q.push_back(eb);
        done_q.push_back(d);
        d0 = dones;
        @(negedge clk);
        stage_i = 3'd5; ir_i = 32'h0; addr_i = 32'hFFFF_FFFF;
        rs2_i = 32'h5555_5555;
        if (has_bus && ack_dly >= 0) begin
            repeat (ack_dly) @(negedge clk);
            bus_ack_i = 1'b1; bus_rdata_i = rdata;
            @(negedge clk);
            bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        end
        for (int i = 0; i < 20 && dones == d0; i++) begin
            @(negedge clk);
            #1;
        end
        if (dones == d0) begin
            compared++;
            mismatched++;
            $display("FAIL done_wait: got no done expected done");
        end
        stage_i = 3'd0;
        @(negedge clk);
    endtask

    bus_t nb;
    int   d_rst;

    initial begin
        nb = mk_bus(1'b0, 32'h0, 32'h0, 4'h0);
        reset = 1'b0; stage_i = 3'd0; ir_i = 32'h0; addr_i = 32'h0;
        rs2_i = 32'h0; bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_we", 32'(bus_we_o), 32'd0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_be", 32'(bus_be_o), 32'd0);
        chk("rst_mem", mem_o, 32'h0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        #1 reset = 1'b1;

        op(32'h0000_2003, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b1,
           mk_bus(1'b0, 32'h100, 32'h0, 4'h0),
           mk_done(32'hDEAD_BEEF, 1'b1, 2'b00, 1));
        op(32'h0000_0003, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b1,
           mk_bus(1'b0, 32'h100, 32'h0, 4'h0),
           mk_done(32'hFFFF_FF80, 1'b1, 2'b00, 1));
        op(32'h0000_4003, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b1,
           mk_bus(1'b0, 32'h100, 32'h0, 4'h0),
           mk_done(32'h0000_0080, 1'b1, 2'b00, 1));
        op(32'h0000_1003, 32'h102, 32'h0, 32'h80FF_1234, 0, 1'b1,
           mk_bus(1'b0, 32'h100, 32'h0, 4'h0),
           mk_done(32'hFFFF_80FF, 1'b1, 2'b00, 1));
        op(32'h0000_0023, 32'h201, 32'h0000_00AB, 32'h0, 0, 1'b1,
           mk_bus(1'b1, 32'h200, 32'hABAB_ABAB, 4'b0010),
           mk_done(32'hFFFF_80FF, 1'b0, 2'b00, 1));
        op(32'h0000_1023, 32'h201, 32'h0000_1234, 32'h0, -1, 1'b0, nb,
           mk_done(32'hFFFF_80FF, 1'b0, 2'b01, 0));
        op(32'h0000_7003, 32'h100, 32'h0, 32'h0, -1, 1'b0, nb,
           mk_done(32'hFFFF_80FF, 1'b0, 2'b10, 0));
        op(32'h0000_0033, 32'h100, 32'h0, 32'h0, -1, 1'b0, nb,
           mk_done(32'hFFFF_80FF, 1'b0, 2'b00, 0));
        op(32'h0000_2003, 32'h104, 32'h0, 32'h0, -1, 1'b1,
           mk_bus(1'b0, 32'h104, 32'h0, 4'h0),
           mk_done(32'hFFFF_80FF, 1'b0, 2'b11, 3));
        op(32'h0000_2023, 32'h300, 32'h1234_5678, 32'h0, 1, 1'b1,
           mk_bus(1'b1, 32'h300, 32'h1234_5678, 4'b1111),
           mk_done(32'hFFFF_80FF, 1'b0, 2'b00, 2));
        op(32'h0000_1023, 32'h102, 32'hBEEF_CAFE, 32'h0, 0, 1'b1,
           mk_bus(1'b1, 32'h100, 32'hCAFE_CAFE, 4'b1100),
           mk_done(32'hFFFF_80FF, 1'b0, 2'b00, 1));
        op(32'h0000_5003, 32'h102, 32'h0, 32'h80FF_1234, 0, 1'b1,
           mk_bus(1'b0, 32'h100, 32'h0, 4'h0),
           mk_done(32'h0000_80FF, 1'b1, 2'b00, 1));
        op(32'h0000_2003, 32'h102, 32'h0, 32'h0, -1, 1'b0, nb,
           mk_done(32'h0000_80FF, 1'b0, 2'b01, 0));
        repeat (2) @(negedge clk);
        chk("err_hold", 32'(err_o), 32'd1);

        // Reset in the middle of a slow load
        @(negedge clk);
        stage_i = 3'd4; ir_i = 32'h0000_2003; addr_i = 32'h100;
        bus_q.push_back(mk_bus(1'b0, 32'h100, 32'h0, 4'h0));
        d_rst = dones;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_req_drop", 32'(bus_req_o), 32'd0);
        chk("async_mem_clr", mem_o, 32'h0);
        chk("async_err_clr", 32'(err_o), 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("idle_after_rst", 32'(bus_req_o), 32'd0);
        chk("no_done_after_rst", 32'(dones), 32'(d_rst));
        stage_i = 3'd0;
        @(negedge clk);
        op(32'h0000_2003, 32'h100, 32'h0, 32'hCAFE_F00D, 0, 1'b1,
           mk_bus(1'b0, 32'h100, 32'h0, 4'h0),
           mk_done(32'hCAFE_F00D, 1'b1, 2'b00, 1));

        repeat (3) @(negedge clk);
        chk("queues_empty", 32'(done_q.size() + bus_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
